// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: FSM state encodings,
// default frame-count constants and small elaboration-time helpers.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_MENU      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int SCORE_W_DEF      = 10;
    localparam int WIN_SCORE_DEF    = 9;
    localparam int SERVE_FRAMES_DEF = 60;
    localparam int POINT_FRAMES_DEF = 30;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the longest pause count, including zero.
    function automatic int timer_width(input int a, input int b);
        return $clog2(max_int(a, b) + 1);
    endfunction

endpackage

// File: rtl/score_controller_frame_timer.sv
// Loadable frame down-counter used for serve and point-hold pauses.
// A load in the same cycle as a frame tick takes priority; the counter
// stops at zero and reports done while it sits there.
module frame_timer #(
    parameter int TW = 6
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          load,
    input  logic [TW-1:0] load_value,
    input  logic          tick,
    output logic          done
);

    logic [TW-1:0] count_r;

    // Frame counter: load has priority, otherwise count down on each frame tick.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_r <= {TW{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (tick && (count_r != {TW{1'b0}})) begin
            count_r <= count_r - {{(TW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == {TW{1'b0}});

endmodule

// File: rtl/score_controller.sv
// Match-sequencing FSM for the two-player game: scoring, serve/point pauses,
// match-end detection and restart handling. All outputs are registered.
// Optional feature macro: WIN_BY_TWO_EN -- when defined, a win also needs a
// lead of at least two points; otherwise first to WIN_SCORE wins outright.
module score_controller
    import pong_pkg::*;
#(
    parameter int SCORE_W      = SCORE_W_DEF,
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int POINT_FRAMES = POINT_FRAMES_DEF
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               menu,
    input  logic               goal_left,
    input  logic               goal_right,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               ball_run,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [2:0]         state,
    output logic               game_over,
    output logic               winner
);

    localparam int TW = timer_width(SERVE_FRAMES, POINT_FRAMES);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ZERO = {SCORE_W{1'b0}};
    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    state_t             state_r;
    state_t             state_next_s;
    logic [SCORE_W-1:0] score1_r;
    logic [SCORE_W-1:0] score2_r;
    logic [SCORE_W-1:0] score1_next_s;
    logic [SCORE_W-1:0] score2_next_s;
    logic               serve_dir_r;
    logic               serve_dir_next_s;
    logic               winner_r;
    logic               winner_next_s;
    logic               ball_run_r;
    logic               ball_reset_r;
    logic               game_over_r;
    logic               scorer_r;          // 0 = player 1 took the last point
    logic               scorer_next_s;
    logic               scorer_valid_r;    // last point actually changed a score
    logic               scorer_valid_next_s;
    logic               start_q_r;
    logic               start_rise_s;
    logic               timer_load_s;
    logic [TW-1:0]      timer_value_s;
    logic               timer_done_s;
    logic [SCORE_W-1:0] scorer_score_s;
    logic               win_s;
`ifdef WIN_BY_TWO_EN
    logic [SCORE_W-1:0] other_score_s;
`endif

    // Saturating score increment: a score never wraps back to zero.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + {{(SCORE_W-1){1'b0}}, 1'b1};
    endfunction

    frame_timer #(
        .TW (TW)
    ) u_frame_timer (
        .clock      (clock),
        .resetn     (resetn),
        .load       (timer_load_s),
        .load_value (timer_value_s),
        .tick       (frame_tick),
        .done       (timer_done_s)
    );

    // Start edge detect; the history register resets high so a held button is ignored.
    assign start_rise_s = start & ~start_q_r;

    // Win evaluation for whoever took the last point.
    always_comb begin
        scorer_score_s = scorer_r ? score2_r : score1_r;
`ifdef WIN_BY_TWO_EN
        other_score_s = scorer_r ? score1_r : score2_r;
        win_s = scorer_valid_r && (scorer_score_s >= WIN_VAL) &&
                (scorer_score_s > other_score_s) &&
                ((scorer_score_s - other_score_s) >= SCORE_W'(2));
`else
        win_s = scorer_valid_r && (scorer_score_s >= WIN_VAL);
`endif
    end

    // Next-state and next-score logic; menu overrides everything else.
    always_comb begin
        state_next_s        = state_r;
        score1_next_s       = score1_r;
        score2_next_s       = score2_r;
        serve_dir_next_s    = serve_dir_r;
        winner_next_s       = winner_r;
        scorer_next_s       = scorer_r;
        scorer_valid_next_s = scorer_valid_r;
        if (menu) begin
            state_next_s  = ST_MENU;
            score1_next_s = SCORE_ZERO;
            score2_next_s = SCORE_ZERO;
        end else begin
            case (state_r)
                ST_MENU: begin
                    score1_next_s = SCORE_ZERO;
                    score2_next_s = SCORE_ZERO;
                    if (start_rise_s) begin
                        state_next_s = ST_SERVE;
                    end else begin
                        state_next_s = ST_MENU;
                    end
                end
                ST_SERVE: begin
                    if (timer_done_s) begin
                        state_next_s = ST_PLAY;
                    end else begin
                        state_next_s = ST_SERVE;
                    end
                end
                ST_PLAY: begin
                    if (goal_left && goal_right) begin
                        state_next_s        = ST_POINT;
                        scorer_valid_next_s = 1'b0;
                    end else if (goal_right) begin
                        state_next_s        = ST_POINT;
                        score1_next_s       = sat_inc(score1_r);
                        serve_dir_next_s    = 1'b0;
                        scorer_next_s       = 1'b0;
                        scorer_valid_next_s = 1'b1;
                    end else if (goal_left) begin
                        state_next_s        = ST_POINT;
                        score2_next_s       = sat_inc(score2_r);
                        serve_dir_next_s    = 1'b1;
                        scorer_next_s       = 1'b1;
                        scorer_valid_next_s = 1'b1;
                    end else begin
                        state_next_s = ST_PLAY;
                    end
                end
                ST_POINT: begin
                    if (timer_done_s && win_s) begin
                        state_next_s  = ST_GAME_OVER;
                        winner_next_s = scorer_r;
                    end else if (timer_done_s) begin
                        state_next_s = ST_SERVE;
                    end else begin
                        state_next_s = ST_POINT;
                    end
                end
                ST_GAME_OVER: begin
                    if (start_rise_s) begin
                        state_next_s        = ST_SERVE;
                        score1_next_s       = SCORE_ZERO;
                        score2_next_s       = SCORE_ZERO;
                        scorer_valid_next_s = 1'b0;
                    end else begin
                        state_next_s = ST_GAME_OVER;
                    end
                end
                default: begin
                    state_next_s  = ST_MENU;
                    score1_next_s = SCORE_ZERO;
                    score2_next_s = SCORE_ZERO;
                end
            endcase
        end
    end

    // Pause timer reload on entry to SERVE or POINT.
    always_comb begin
        if ((state_next_s == ST_SERVE) && (state_r != ST_SERVE)) begin
            timer_load_s  = 1'b1;
            timer_value_s = TW'(SERVE_FRAMES);
        end else if ((state_next_s == ST_POINT) && (state_r != ST_POINT)) begin
            timer_load_s  = 1'b1;
            timer_value_s = TW'(POINT_FRAMES);
        end else begin
            timer_load_s  = 1'b0;
            timer_value_s = {TW{1'b0}};
        end
    end

    // State, score and registered output update.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r        <= ST_MENU;
            score1_r       <= SCORE_ZERO;
            score2_r       <= SCORE_ZERO;
            serve_dir_r    <= 1'b0;
            winner_r       <= 1'b0;
            scorer_r       <= 1'b0;
            scorer_valid_r <= 1'b0;
            ball_run_r     <= 1'b0;
            ball_reset_r   <= 1'b0;
            game_over_r    <= 1'b0;
            start_q_r      <= 1'b1;
        end else begin
            state_r        <= state_next_s;
            score1_r       <= score1_next_s;
            score2_r       <= score2_next_s;
            serve_dir_r    <= serve_dir_next_s;
            winner_r       <= winner_next_s;
            scorer_r       <= scorer_next_s;
            scorer_valid_r <= scorer_valid_next_s;
            ball_run_r     <= (state_next_s == ST_PLAY);
            ball_reset_r   <= (state_next_s == ST_SERVE) && (state_r != ST_SERVE);
            game_over_r    <= (state_next_s == ST_GAME_OVER);
            start_q_r      <= start;
        end
    end

    assign score1     = score1_r;
    assign score2     = score2_r;
    assign ball_run   = ball_run_r;
    assign ball_reset = ball_reset_r;
    assign serve_dir  = serve_dir_r;
    assign state      = state_r;
    assign game_over  = game_over_r;
    assign winner     = winner_r;

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller: match flow, goal handling, win
// detection (plain or WIN_BY_TWO_EN), menu override and async reset.
module tb_score_controller;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       menu = 1'b0;
    logic       goal_left = 1'b0;
    logic       goal_right = 1'b0;
    logic [9:0] score1;
    logic [9:0] score2;
    logic       ball_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [2:0] state;
    logic       game_over;
    logic       winner;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] S_MENU  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    score_controller dut (
        .clock      (clock),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .start      (start),
        .menu       (menu),
        .goal_left  (goal_left),
        .goal_right (goal_right),
        .score1     (score1),
        .score2     (score2),
        .ball_run   (ball_run),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .state      (state),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic serve_to_play();
        ticks(60);
        step();
        chk("serve_to_play", state, S_PLAY);
    endtask

    task automatic score_point(input logic right);
        serve_to_play();
        if (right) begin
            goal_right = 1'b1;
        end else begin
            goal_left = 1'b1;
        end
        step();
        goal_right = 1'b0;
        goal_left  = 1'b0;
        ticks(30);
        step();
    endtask

    initial begin
        // reset with start held high
        resetn = 1'b0;
        start  = 1'b1;
        repeat (3) step();
        chk("rst_state", state, S_MENU);
        chk("rst_score1", score1, 0);
        chk("rst_score2", score2, 0);
        chk("rst_ball_run", ball_run, 0);
        chk("rst_ball_reset", ball_reset, 0);
        chk("rst_serve_dir", serve_dir, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_winner", winner, 0);
        resetn = 1'b1;
        step();
        step();
        chk("start_held_no_trigger", state, S_MENU);
        start = 1'b0;
        step();

        // start -> SERVE with one ball_reset pulse
        start = 1'b1;
        step();
        chk("start_serve", state, S_SERVE);
        chk("start_ball_reset", ball_reset, 1);
        start = 1'b0;
        step();
        chk("ball_reset_one_cycle", ball_reset, 0);

        // serve pause: 59 ticks still serving, 60th releases play
        ticks(59);
        step();
        step();
        chk("serve_hold", state, S_SERVE);
        chk("serve_hold_run", ball_run, 0);
        ticks(1);
        step();
        chk("play_state", state, S_PLAY);
        chk("play_ball_run", ball_run, 1);

        // goal_right -> player 1 scores
        goal_right = 1'b1;
        step();
        goal_right = 1'b0;
        chk("gr_score1", score1, 1);
        chk("gr_score2", score2, 0);
        chk("gr_state", state, S_POINT);
        chk("gr_serve_dir", serve_dir, 0);
        chk("gr_ball_run", ball_run, 0);
        ticks(29);
        step();
        chk("point_hold", state, S_POINT);
        ticks(1);
        step();
        chk("point_to_serve", state, S_SERVE);
        chk("point_ball_reset", ball_reset, 1);
        step();
        chk("point_ball_reset_end", ball_reset, 0);

        // goal outside PLAY is ignored
        goal_right = 1'b1;
        step();
        goal_right = 1'b0;
        chk("goal_in_serve_ignored", score1, 1);
        chk("goal_in_serve_state", state, S_SERVE);

        // goal_left -> player 2 scores, serve toward right
        serve_to_play();
        goal_left = 1'b1;
        step();
        goal_left = 1'b0;
        chk("gl_score2", score2, 1);
        chk("gl_serve_dir", serve_dir, 1);
        chk("gl_state", state, S_POINT);
        ticks(30);
        step();
        chk("gl_to_serve", state, S_SERVE);

        // both goals together: no score, serve_dir kept
        serve_to_play();
        goal_left  = 1'b1;
        goal_right = 1'b1;
        step();
        goal_left  = 1'b0;
        goal_right = 1'b0;
        chk("both_score1", score1, 1);
        chk("both_score2", score2, 1);
        chk("both_state", state, S_POINT);
        chk("both_serve_dir", serve_dir, 1);
        ticks(30);
        step();
        chk("both_to_serve", state, S_SERVE);

        // build 8-3, then 9-3 ends the match
        for (int i = 0; i < 2; i++) score_point(1'b0);
        for (int i = 0; i < 7; i++) score_point(1'b1);
        chk("s8_3_score1", score1, 8);
        chk("s8_3_score2", score2, 3);
        chk("s8_3_state", state, S_SERVE);
        score_point(1'b1);
        chk("s9_3_score1", score1, 9);
        chk("s9_3_state", state, S_OVER);
        chk("s9_3_game_over", game_over, 1);
        chk("s9_3_winner", winner, 0);

        // goals ignored while game over
        goal_right = 1'b1;
        step();
        goal_right = 1'b0;
        goal_left = 1'b1;
        step();
        goal_left = 1'b0;
        chk("over_frozen_score1", score1, 9);
        chk("over_frozen_score2", score2, 3);
        chk("over_frozen_state", state, S_OVER);

        // restart from game over
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_score1", score1, 0);
        chk("restart_score2", score2, 0);
        chk("restart_state", state, S_SERVE);
        chk("restart_ball_reset", ball_reset, 1);
        chk("restart_game_over", game_over, 0);
        step();

        // close match from 8-8
        for (int i = 0; i < 8; i++) score_point(1'b1);
        for (int i = 0; i < 8; i++) score_point(1'b0);
        chk("s8_8_state", state, S_SERVE);
`ifdef WIN_BY_TWO_EN
        score_point(1'b1);
        chk("s9_8_score1", score1, 9);
        chk("s9_8_continues", state, S_SERVE);
        score_point(1'b1);
        chk("s10_8_score1", score1, 10);
        chk("s10_8_state", state, S_OVER);
        chk("s10_8_winner", winner, 0);
`else
        score_point(1'b0);
        chk("s8_9_score2", score2, 9);
        chk("s8_9_state", state, S_OVER);
        chk("s8_9_winner", winner, 1);
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart2_state", state, S_SERVE);

        // menu overrides a simultaneous goal mid-play
        score_point(1'b1);
        chk("pre_menu_score1", score1, 1);
        serve_to_play();
        menu       = 1'b1;
        goal_right = 1'b1;
        step();
        menu       = 1'b0;
        goal_right = 1'b0;
        chk("menu_state", state, S_MENU);
        chk("menu_score1", score1, 0);
        chk("menu_score2", score2, 0);
        chk("menu_ball_run", ball_run, 0);

        // async reset in POINT
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("menu_restart_state", state, S_SERVE);
        serve_to_play();
        goal_right = 1'b1;
        step();
        goal_right = 1'b0;
        chk("pre_reset_state", state, S_POINT);
        chk("pre_reset_score1", score1, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_state", state, S_MENU);
        chk("async_rst_score1", score1, 0);
        step();
        resetn = 1'b1;
        step();
        chk("post_rst_state", state, S_MENU);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
